// File: rtl/stream_demultiplexor.sv
// -----------------------------------------------------------------------------
// stream_demultiplexor
// Packet-aware valid/ready demultiplexor: routes one input stream to one of
// CH_NUM output channels. The destination is taken from in_addr on the first
// beat of a packet and held until its last beat. Beats pass through a single
// output register. Packets addressed beyond CH_NUM-1 are consumed and dropped,
// with a one-cycle err pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_data    input beat data
//   in_last    final beat of packet
//   in_addr    destination channel, meaningful on first beat only
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready (combinational)
//   out_data   per-channel data, every channel carries the register value
//   out_last   per-channel last, every channel carries the register value
//   out_valid  per-channel valid, at most one bit set
//   out_ready  per-channel ready, only the selected channel is observed
//   err        one-cycle pulse after the first beat of a dropped packet
//   busy       packet in progress or output register occupied
// -----------------------------------------------------------------------------
module stream_demultiplexor #(
  parameter int unsigned DWIDTH = 2,
  parameter int unsigned CH_NUM = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DWIDTH-1:0]                in_data,
  input  logic                             in_last,
  input  logic [$clog2(CH_NUM)-1:0]        in_addr,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [CH_NUM-1:0][DWIDTH-1:0]    out_data,
  output logic [CH_NUM-1:0]                out_last,
  output logic [CH_NUM-1:0]                out_valid,
  input  logic [CH_NUM-1:0]                out_ready,
  output logic                             err,
  output logic                             busy
);

  localparam int unsigned AW = $clog2(CH_NUM);
  // One extra bit so the range check also works when CH_NUM is a power of two.
  localparam logic [AW:0] CH_LIM = (AW+1)'(CH_NUM);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PASS = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              reg_valid;
  logic [DWIDTH-1:0] reg_data;
  logic              reg_last;
  logic [AW-1:0]     sel;

  logic              addr_ok;
  logic              sel_ready;
  logic              can_load;
  logic              accept;
  logic              load;
  logic              load_sel;
  logic              drop_first;

  assign addr_ok  = ({1'b0, in_addr} < CH_LIM);
  assign can_load = !reg_valid || sel_ready;
  assign accept   = in_valid && in_ready;

  // Ready of the currently selected channel; other channels are ignored.
  always_comb begin
    sel_ready = 1'b0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (sel == AW'(i)) sel_ready = out_ready[i];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && !in_last) state_nxt = addr_ok ? S_PASS : S_DROP;
      end
      S_PASS, S_DROP: begin
        if (accept && in_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs. A new first beat waits for can_load, so the previous
  // packet's last beat drains on the old sel before sel changes.
  always_comb begin
    in_ready   = 1'b0;
    load       = 1'b0;
    load_sel   = 1'b0;
    drop_first = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (addr_ok) begin
            in_ready = can_load;
            load     = in_valid && can_load;
            load_sel = in_valid && can_load;
          end else begin
            in_ready   = 1'b1;
            drop_first = in_valid;
          end
        end
        S_PASS: begin
          in_ready = can_load;
          load     = in_valid && can_load;
        end
        S_DROP: begin
          in_ready = 1'b1;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  // Output register; a load in the same cycle as a drain keeps reg_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_valid <= 1'b0;
      reg_data  <= '0;
      reg_last  <= 1'b0;
      sel       <= '0;
      err       <= 1'b0;
    end else begin
      err <= drop_first;
      if (load) begin
        reg_valid <= 1'b1;
        reg_data  <= in_data;
        reg_last  <= in_last;
      end else if (reg_valid && sel_ready) begin
        reg_valid <= 1'b0;
      end
      if (load_sel) sel <= in_addr;
    end
  end

  // Channel fan-out of the single register.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      out_valid[i] = reg_valid && (sel == AW'(i));
      out_data[i]  = reg_data;
      out_last[i]  = reg_last;
    end
  end

  assign busy = (state != S_IDLE) || reg_valid;

endmodule

// File: tb/tb_stream_demultiplexor.sv
// -----------------------------------------------------------------------------
// tb_stream_demultiplexor
// Directed scenarios plus randomized packets for stream_demultiplexor
// (DWIDTH=8, CH_NUM=3). Expected output is a packet-level queue of beats in
// acceptance order; dropped packets add an expected err pulse.
// -----------------------------------------------------------------------------
module tb_stream_demultiplexor;

  localparam int unsigned DW = 8;
  localparam int unsigned CH = 3;
  localparam int unsigned AW = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [DW-1:0]          in_data;
  logic                   in_last;
  logic [AW-1:0]          in_addr;
  logic                   in_valid;
  logic                   in_ready;
  logic [CH-1:0][DW-1:0]  out_data;
  logic [CH-1:0]          out_last;
  logic [CH-1:0]          out_valid;
  logic [CH-1:0]          out_ready;
  logic                   err;
  logic                   busy;

  stream_demultiplexor #(.DWIDTH(DW), .CH_NUM(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [DW-1:0] d;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    acc_q[$];
  int    xf_ch[$];
  int    xf_cyc[$];
  int    cyc      = 0;
  int    err_exp  = 0;
  int    err_seen = 0;
  int    n_cmp    = 0;
  int    n_err    = 0;
  bit    rnd_rdy  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Randomized channel readiness, biased toward ready.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(2) == 0) ? CH'($urandom) : 3'b111;
  end

  // Output monitor: transfers against the expected queue, hold-while-stalled.
  initial begin
    bit            stall;
    logic [CH-1:0] st_v;
    logic [23:0]   st_d;
    logic [CH-1:0] st_l;
    beat_t         e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        check("valid_onehot", 32'($countones(out_valid) <= 1), 32'd1);
        if (stall) begin
          check("hold_valid", 32'(out_valid), 32'(st_v));
          check("hold_data", 32'(out_data), 32'(st_d));
          check("hold_last", 32'(out_last), 32'(st_l));
        end
        for (int i = 0; i < CH; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            check("xfer_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check("xfer_ch", 32'(i), 32'(e.ch));
              check("xfer_data", 32'(out_data[i]), 32'(e.d));
              check("xfer_last", 32'(out_last[i]), 32'(e.l));
            end
            xf_ch.push_back(i);
            xf_cyc.push_back(cyc);
          end
        end
        stall = (out_valid != '0) && ((out_valid & out_ready) == '0);
        st_v  = out_valid;
        st_d  = out_data;
        st_l  = out_last;
        if (err) err_seen++;
      end
    end
  end

  // Present one beat from posedge+1 and hold it until accepted.
  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [AW-1:0] a);
    int w;
    w        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    in_addr  = a;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    acc_q.push_back(cyc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_last  = 1'($urandom);
    in_addr  = AW'($urandom);
  endtask

  // Send a packet and record what it should produce. Non-first beats carry a
  // random in_addr, which must be ignored.
  task automatic send_pkt(input logic [AW-1:0] a, input logic [DW-1:0] ds[$],
                          input bit term, input bit gaps);
    logic          l;
    logic [AW-1:0] aa;
    beat_t         b;
    for (int i = 0; i < ds.size(); i++) begin
      if (gaps && $urandom_range(2) == 0) begin
        @(posedge clk);
        #1;
      end
      l  = term && (i == ds.size() - 1);
      aa = (i == 0) ? a : AW'($urandom);
      send_beat(ds[i], l, aa);
      if (int'(a) < CH) begin
        b.ch = int'(a);
        b.d  = ds[i];
        b.l  = l;
        exp_q.push_back(b);
      end else if (i == 0) begin
        err_exp++;
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    xf_ch.delete();
    xf_cyc.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] dq[$];
    int            s;
    int            e0;

    // Reset held two cycles with in_valid high.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h5A;
    in_last   = 1'b0;
    in_addr   = 2'd0;
    out_ready = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;

    // 3-beat packet to ch2 at full throughput, 1-cycle latency.
    clear_logs();
    dq = '{8'h11, 8'h22, 8'h33};
    send_pkt(2'd2, dq, 1'b1, 1'b0);
    drain();
    check("t1_xfers", 32'(xf_cyc.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t1_accept_rate", 32'(acc_q[i]), 32'(acc_q[0] + i));
      check("t1_latency", 32'(xf_cyc[i]), 32'(acc_q[i] + 1));
    end

    // Back-to-back single-beat packets, no bubble.
    clear_logs();
    dq = '{8'hA0};
    send_pkt(2'd0, dq, 1'b1, 1'b0);
    dq = '{8'hB1};
    send_pkt(2'd1, dq, 1'b1, 1'b0);
    drain();
    check("t2_xfers", 32'(xf_cyc.size()), 32'd2);
    check("t2_no_bubble", 32'(xf_cyc[1]), 32'(xf_cyc[0] + 1));

    // Backpressure on ch1; other channel readies toggle.
    clear_logs();
    out_ready = 3'b101;
    dq = '{8'h51, 8'h52};
    fork
      send_pkt(2'd1, dq, 1'b1, 1'b0);
      begin
        s = 0;
        do begin
          @(posedge clk);
          #1;
          s++;
        end while (acc_q.size() == 0 && s < 50);
        repeat (3) begin
          @(negedge clk);
          check("t3_out_valid", 32'(out_valid), 32'b010);
          check("t3_held_data", 32'(out_data[1]), 32'h51);
          check("t3_in_ready", 32'(in_ready), 32'd0);
          @(posedge clk);
          #1;
          out_ready[0] = ~out_ready[0];
          out_ready[2] = ~out_ready[2];
        end
        out_ready = 3'b111;
      end
    join
    drain();
    check("t3_xfers", 32'(xf_cyc.size()), 32'd2);

    // Invalid address: consumed at full rate, one err pulse, nothing out.
    clear_logs();
    e0 = err_seen;
    s  = cyc;
    dq = '{8'hDE, 8'hAD};
    send_pkt(2'd3, dq, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("t4_first_accept", 32'(acc_q[0]), 32'(s));
    check("t4_second_accept", 32'(acc_q[1]), 32'(s + 1));
    check("t4_err_pulses", 32'(err_seen - e0), 32'd1);
    check("t4_no_output", 32'(xf_cyc.size()), 32'd0);
    dq = '{8'h07, 8'h08};
    send_pkt(2'd0, dq, 1'b1, 1'b0);
    drain();

    // Channel switch waits for the held ch2 last beat to drain.
    clear_logs();
    out_ready = 3'b011;
    dq = '{8'hC2};
    send_pkt(2'd2, dq, 1'b1, 1'b0);
    dq = '{8'hC0};
    fork
      send_pkt(2'd0, dq, 1'b1, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("t5_in_ready", 32'(in_ready), 32'd0);
          check("t5_out_valid", 32'(out_valid), 32'b100);
        end
        @(posedge clk);
        #1;
        out_ready = 3'b111;
      end
    join
    drain();
    check("t5_xfers", 32'(xf_ch.size()), 32'd2);
    check("t5_first_ch", 32'(xf_ch[0]), 32'd2);
    check("t5_second_ch", 32'(xf_ch[1]), 32'd0);
    check("t5_switch_gap", 32'(xf_cyc[1]), 32'(xf_cyc[0] + 1));

    // Reset in the middle of a 4-beat ch1 packet.
    clear_logs();
    dq = '{8'h61, 8'h62};
    send_pkt(2'd1, dq, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
    dq = '{8'h63};
    send_pkt(2'd2, dq, 1'b1, 1'b0);
    drain();
    check("t6_xfers", 32'(xf_ch.size()), 32'd1);
    check("t6_new_first_ch", 32'(xf_ch[0]), 32'd2);

    // Randomized packets, addresses 0..3, random gaps and readiness.
    rnd_rdy = 1'b1;
    for (int p = 0; p < 80; p++) begin
      int n;
      n = $urandom_range(4, 1);
      dq.delete();
      for (int k = 0; k < n; k++) dq.push_back(DW'($urandom));
      send_pkt(AW'($urandom_range(3)), dq, 1'b1, 1'b1);
    end
    rnd_rdy = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 3'b111;
    drain();
    repeat (2) @(posedge clk);
    #1;
    check("final_err_count", 32'(err_seen), 32'(err_exp));
    check("final_busy", 32'(busy), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stream_demultiplexor.md
Name: stream_demultiplexor

Overview:
Packet-aware valid/ready demultiplexor. It routes one input stream to one of CH_NUM output channels, which is the inverse of the team's channel multiplexor.
- The destination address is sampled on the first beat of each packet and held until the last beat.
- Beats pass through a single registered stage.
- Packets with an out-of-range address are consumed and dropped, and an error is flagged.

Parameters:
DWIDTH, 2, data width per beat in bits
CH_NUM, 3, number of output channels (must be >= 2)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  DWIDTH  input beat data
in_last  input  1  marks final beat of packet
in_addr  input  $clog2(CH_NUM)  destination channel, valid on first beat only
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
out_data  output  [CH_NUM-1:0][DWIDTH-1:0]  per-channel data (all channels carry the register value)
out_last  output  CH_NUM  per-channel last (all channels carry the register value)
out_valid  output  CH_NUM  per-channel valid, at most one bit set
out_ready  input  CH_NUM  per-channel ready
err  output  1  one-cycle pulse on first beat of a dropped packet
busy  output  1  state != IDLE or output register occupied

Behaviour:
Reset (synchronous, active-high):
- rst high at a clock edge: state=IDLE, reg_valid=0, sel=0, reg_data=0, reg_last=0, err=0.
- All outputs are therefore 0: out_valid=0, out_data=0, out_last=0, in_ready=0 during reset, busy=0.
- Reset mid-packet discards the held beat and the packet context. The next accepted beat is treated as a first beat.

Output register:
- One entry: reg_valid, reg_data, reg_last, sel.
- out_valid[i] = reg_valid && (sel == i).
- out_data[i] = reg_data and out_last[i] = reg_last for every i.
- Transfer on channel sel occurs when reg_valid && out_ready[sel]. out_ready of other channels is ignored.
- While out_valid is high and unaccepted, out_data and out_last are held stable.

Latency and throughput:
- 1 cycle from input acceptance to out_valid.
- Full throughput (one beat per cycle) when out_ready[sel] stays high.
- can_load = !reg_valid || out_ready[sel].

State machine:
- IDLE (awaiting first beat):
  - Valid address (in_addr < CH_NUM): in_ready = can_load. On acceptance, sel <= in_addr, the register loads the beat, and state goes to PASS if !in_last, otherwise stays IDLE.
  - Because in_ready requires can_load, the previous packet's last beat drains on the old sel before sel changes.
  - Invalid address (in_addr >= CH_NUM): in_ready = 1. The beat is discarded, err pulses in the next cycle, and state goes to DROP if !in_last. Register and sel are unaffected.
- PASS:
  - in_ready = can_load; in_addr is ignored.
  - Each accepted beat loads the register.
  - An accepted beat with in_last returns state to IDLE.
- DROP:
  - in_ready = 1; beats are discarded, no err.
  - An accepted beat with in_last returns state to IDLE.

Other rules:
- Load and drain in the same cycle: the register takes the new beat, reg_valid stays 1, and no bubble is inserted.
- in_valid low: no state change. The register may still drain.
- err is registered, high for exactly one cycle per dropped packet.
- A single-beat packet (in_last on first beat) never leaves IDLE.
- in_ready may depend combinationally on out_ready[sel]. in_valid must not depend on in_ready; the upstream holds data while unaccepted.
- busy = (state != IDLE) || reg_valid.

Test Plan:
- DWIDTH=8, CH_NUM=3, rst held 2 cycles → all outputs 0 and busy=0. Then 3-beat packet addr=2, data 0x11,0x22,0x33, out_ready=3'b111 → out_valid=3'b100 for 3 consecutive cycles starting 1 cycle after the first accept, data 0x11/0x22/0x33, out_last only with 0x33.
- Back-to-back single-beat packets addr=0 data 0xA0, then addr=1 data 0xB1, all ready → out_valid 3'b001 then 3'b010 in consecutive cycles with no bubble.
- Backpressure: addr=1, 2 beats, out_ready[1]=0 for 3 cycles → out_valid=3'b010, out_data holds the first beat stable, in_ready=0. out_ready[0] and out_ready[2] toggling has no effect. Release → both beats delivered in order.
- Invalid address in_addr=3 with 2-beat packet 0xDE,0xAD → in_ready=1 both beats, err=1 for exactly one cycle, out_valid stays 0. A following addr=0 packet routes normally.
- Channel switch while draining: last beat to ch2 held (out_ready[2]=0), next packet first beat addr=0 presented → in_ready=0 until out_ready[2]=1. Then ch2 completes, and ch0 gets its beat 1 cycle later.
- Reset mid-packet: rst asserted after beat 2 of a 4-beat addr=1 packet → next cycle out_valid=0, busy=0. The next beat with in_addr=2 is treated as a first beat and routed to ch2.
